// File: rtl/power_test_pkg.sv
// Shared types and helpers for the power activity bank.
// lfsr_next is only referenced when PWR_ACT_BANK_LFSR_EN is defined.
package power_test_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RAMP_UP   = 2'd1,
    RUN       = 2'd2,
    RAMP_DOWN = 2'd3
  } act_state_e;

  localparam int SIG_W      = 32;
  localparam int LFSR_MAX_W = 64;

  // Value is right-aligned in LFSR_MAX_W bits; w is the live counter width (4..64).
  // A zero state is replaced by idx+1 so no counter can lock up.
  function automatic logic [LFSR_MAX_W-1:0] lfsr_next(input logic [LFSR_MAX_W-1:0] value,
                                                      input int w,
                                                      input int idx);
    logic [LFSR_MAX_W-1:0] mask;
    logic [LFSR_MAX_W-1:0] taps;
    logic [LFSR_MAX_W-1:0] nxt;
    mask = (w >= LFSR_MAX_W) ? '1 : ((64'd1 << w) - 64'd1);
    taps = (64'd1 << (w - 1)) | (64'd1 << (w - 2)) | (64'd1 << (w - 4)) | 64'd1;
    if ((value & mask) == '0)
      nxt = LFSR_MAX_W'(idx + 1);
    else
      nxt = {value[LFSR_MAX_W-2:0], ^(value & taps)};
    return nxt & mask;
  endfunction

endpackage

// File: rtl/power_activity_bank_channel.sv
// act_channel: one channel of CTR_PER_CH activity counters with a 1-bit parity tap.
// LFSR stepping exists only when PWR_ACT_BANK_LFSR_EN is defined; otherwise counters are binary.
module act_channel
  import power_test_pkg::*;
#(
  parameter int W          = 32,
  parameter int CTR_PER_CH = 64,
  parameter int CH_IDX     = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_gate,
  input  logic i_mode,
  output logic o_chtap
);

  logic                  w_step;
  logic [W-1:0]          w_next [CTR_PER_CH];
  logic [CTR_PER_CH-1:0] w_tap;

  (* keep = "true", dont_touch = "true" *) logic [W-1:0] r_ctr [CTR_PER_CH];

  assign w_step = i_en & i_gate;

`ifdef PWR_ACT_BANK_LFSR_EN
  always_comb begin
    for (int j = 0; j < CTR_PER_CH; j++) begin
      w_next[j] = r_ctr[j] + 1'b1;
      if (i_mode)
        w_next[j] = W'(lfsr_next(LFSR_MAX_W'(r_ctr[j]), W, CH_IDX * CTR_PER_CH + j));
    end
  end
`else
  logic w_mode_unused;
  assign w_mode_unused = i_mode;

  always_comb begin
    for (int j = 0; j < CTR_PER_CH; j++) begin
      w_next[j] = r_ctr[j] + 1'b1;
    end
  end
`endif

  always_comb begin
    for (int j = 0; j < CTR_PER_CH; j++) begin
      w_tap[j] = ^r_ctr[j];
    end
  end

  assign o_chtap = ^w_tap;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int j = 0; j < CTR_PER_CH; j++) r_ctr[j] <= '0;
    end else if (w_step) begin
      for (int j = 0; j < CTR_PER_CH; j++) r_ctr[j] <= w_next[j];
    end
  end

endmodule

// File: rtl/power_activity_bank.sv
// Ramped, duty-gated counter bank for power characterisation with a rotating-XOR signature.
// Define PWR_ACT_BANK_LFSR_EN to build the LFSR counting mode.
module power_activity_bank
  import power_test_pkg::*;
#(
  parameter int NUM_CH     = 8,
  parameter int CTR_PER_CH = 64,
  parameter int W          = 32,
  parameter int RAMP_STEP  = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_start,
  input  logic                          i_stop,
  input  logic [$clog2(NUM_CH+1)-1:0]   i_tgt_ch,
  input  logic [8:0]                    i_duty,
  input  logic                          i_mode,
  output logic                          o_busy,
  output logic                          o_at_target,
  output logic [$clog2(NUM_CH+1)-1:0]   o_active_ch,
  output logic [SIG_W-1:0]              o_signature
);

  localparam int CH_W  = $clog2(NUM_CH + 1);
  localparam int TMR_W = (RAMP_STEP > 1) ? $clog2(RAMP_STEP) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(RAMP_STEP - 1);
  localparam logic [CH_W-1:0]  CH_MAX   = CH_W'(NUM_CH);

  act_state_e r_state;
  logic [CH_W-1:0]  r_target;
  logic [CH_W-1:0]  r_active;
  logic [TMR_W-1:0] r_timer;
  logic [7:0]       r_phase;
  logic             r_busy;
  logic             r_at_target;

  (* keep = "true", dont_touch = "true" *) logic [SIG_W-1:0] r_sig;

  logic              w_gate;
  logic              w_tmr_done;
  logic [CH_W-1:0]   w_tgt_clamped;
  logic [CH_W-1:0]   w_active_inc;
  logic [NUM_CH-1:0] w_en;
  logic [NUM_CH-1:0] w_chtap;

  // Phase never exceeds 255, so any duty >= 256 opens the gate every cycle.
  assign w_gate        = ({1'b0, r_phase} < i_duty);
  assign w_tmr_done    = (r_timer == TMR_LAST);
  assign w_tgt_clamped = (i_tgt_ch > CH_MAX) ? CH_MAX : i_tgt_ch;
  assign w_active_inc  = r_active + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_target    <= '0;
      r_active    <= '0;
      r_timer     <= '0;
      r_phase     <= '0;
      r_busy      <= 1'b0;
      r_at_target <= 1'b0;
    end else begin
      r_phase     <= r_phase + 8'd1;
      r_busy      <= (r_state != IDLE);
      r_at_target <= (r_state == RUN);
      case (r_state)
        IDLE: begin
          if (i_start && !i_stop && (i_tgt_ch != '0)) begin
            r_target <= w_tgt_clamped;
            r_timer  <= '0;
            r_state  <= RAMP_UP;
          end
        end
        RAMP_UP: begin
          if (i_stop) begin
            r_timer <= '0;
            r_state <= RAMP_DOWN;
          end else if (w_tmr_done) begin
            r_timer  <= '0;
            r_active <= w_active_inc;
            if (w_active_inc == r_target) r_state <= RUN;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        RUN: begin
          if (i_stop) begin
            r_timer <= '0;
            r_state <= RAMP_DOWN;
          end
        end
        RAMP_DOWN: begin
          // A stop before the first channel came on leaves nothing to ramp down.
          if (r_active == '0) begin
            r_state <= IDLE;
          end else if (w_tmr_done) begin
            r_timer  <= '0;
            r_active <= r_active - 1'b1;
            if (r_active == CH_W'(1)) r_state <= IDLE;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    assign w_en[gi] = (CH_W'(gi) < r_active);

    act_channel #(
      .W          (W),
      .CTR_PER_CH (CTR_PER_CH),
      .CH_IDX     (gi)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .i_en    (w_en[gi]),
      .i_gate  (w_gate),
      .i_mode  (i_mode),
      .o_chtap (w_chtap[gi])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_sig <= '0;
    else     r_sig <= {r_sig[SIG_W-2:0], r_sig[SIG_W-1]} ^ SIG_W'(w_chtap);
  end

  assign o_busy      = r_busy;
  assign o_at_target = r_at_target;
  assign o_active_ch = r_active;
  assign o_signature = r_sig;

endmodule

// File: tb/tb_power_activity_bank.sv
// Directed bench for power_activity_bank: ramp timing, clamp/ignore rules, duty gate, LFSR, signature, reset.
module tb_power_activity_bank;

  localparam int NUM_CH     = 8;
  localparam int CTR_PER_CH = 3;
  localparam int W          = 8;
  localparam int RAMP_STEP  = 16;
  localparam int CH_W       = $clog2(NUM_CH + 1);

  logic            clk   = 1'b0;
  logic            rst   = 1'b1;
  logic            start = 1'b0;
  logic            stop  = 1'b0;
  logic            mode  = 1'b0;
  logic [CH_W-1:0] tgt   = '0;
  logic [8:0]      duty  = '0;
  logic            busy;
  logic            at_target;
  logic [CH_W-1:0] active_ch;
  logic [31:0]     signature;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  power_activity_bank #(
    .NUM_CH     (NUM_CH),
    .CTR_PER_CH (CTR_PER_CH),
    .W          (W),
    .RAMP_STEP  (RAMP_STEP)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_start     (start),
    .i_stop      (stop),
    .i_tgt_ch    (tgt),
    .i_duty      (duty),
    .i_mode      (mode),
    .o_busy      (busy),
    .o_at_target (at_target),
    .o_active_ch (active_ch),
    .o_signature (signature)
  );

  logic [W-1:0] c00, c01, c02, c10, c72;
  assign c00 = dut.g_ch[0].u_ch.r_ctr[0];
  assign c01 = dut.g_ch[0].u_ch.r_ctr[1];
  assign c02 = dut.g_ch[0].u_ch.r_ctr[2];
  assign c10 = dut.g_ch[1].u_ch.r_ctr[0];
  assign c72 = dut.g_ch[7].u_ch.r_ctr[2];

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start(input logic [CH_W-1:0] t);
    tgt   = t;
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(1);
  endtask

  initial begin
    logic [W-1:0] s0;
    logic [W-1:0] s7;
    logic [W-1:0] d;
    logic         nz_ok;

    // reset and idle
    tick(2);
    rst = 1'b0;
    tick(5);
    check("idle_busy",      32'(busy),      32'd0);
    check("idle_active",    32'(active_ch), 32'd0);
    check("idle_at_target", 32'(at_target), 32'd0);
    check("idle_sig",       signature,      32'd0);

    // ramp up to 4 channels, then down
    pulse_start(4);
    tick(15);
    check("ramp_c15", 32'(active_ch), 32'd0);
    check("ramp_busy", 32'(busy), 32'd1);
    tick(1);
    check("ramp_c16", 32'(active_ch), 32'd1);
    tick(16);
    check("ramp_c32", 32'(active_ch), 32'd2);
    tick(16);
    check("ramp_c48", 32'(active_ch), 32'd3);
    tick(16);
    check("ramp_c64", 32'(active_ch), 32'd4);
    check("ramp_at_c64", 32'(at_target), 32'd0);
    tick(1);
    check("ramp_at_c65", 32'(at_target), 32'd1);
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    tick(63);
    check("down_s63", 32'(active_ch), 32'd1);
    tick(1);
    check("down_s64", 32'(active_ch), 32'd0);
    check("down_busy_s64", 32'(busy), 32'd1);
    tick(1);
    check("down_busy_s65", 32'(busy), 32'd0);

    // target clamped to NUM_CH
    pulse_start(12);
    tick(127);
    check("clamp_c127", 32'(active_ch), 32'd7);
    tick(1);
    check("clamp_c128", 32'(active_ch), 32'd8);
    tick(1);
    check("clamp_at", 32'(at_target), 32'd1);

    // duty gate with all channels in RUN
    duty = 9'd64;
    s0 = c00;
    s7 = c72;
    tick(256);
    d = c00 - s0;
    check("duty64_ch0", 32'(d), 32'd64);
    d = c72 - s7;
    check("duty64_ch7", 32'(d), 32'd64);
    duty = 9'd0;
    s0 = c00;
    tick(50);
    d = c00 - s0;
    check("duty0_frozen", 32'(d), 32'd0);
    duty = 9'd300;
    s0 = c00;
    tick(50);
    d = c00 - s0;
    check("duty300_every", 32'(d), 32'd50);
    duty = 9'd0;

    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    tick(128);
    check("down8_active", 32'(active_ch), 32'd0);
    tick(2);
    check("down8_busy", 32'(busy), 32'd0);

    // start with zero target is ignored
    pulse_start(0);
    tick(20);
    check("zero_tgt_busy",   32'(busy),      32'd0);
    check("zero_tgt_active", 32'(active_ch), 32'd0);

    // start and stop together during ramp-up: stop wins
    pulse_start(3);
    tick(32);
    check("both_pre", 32'(active_ch), 32'd2);
    start = 1'b1;
    stop  = 1'b1;
    tick(1);
    start = 1'b0;
    stop  = 1'b0;
    tick(15);
    check("both_hold", 32'(active_ch), 32'd2);
    tick(1);
    check("both_dec", 32'(active_ch), 32'd1);
    check("both_not_run", 32'(at_target), 32'd0);
    tick(16);
    check("both_zero", 32'(active_ch), 32'd0);
    tick(2);
    check("both_busy", 32'(busy), 32'd0);

    // signature after a single step of channel 0 (odd counter count -> tap 1)
    reset_pulse();
    check("sig_rst", signature, 32'd0);
    check("ctr_rst", 32'(c00), 32'd0);
    pulse_start(1);
    tick(17);
    duty = 9'd300;
    tick(1);
    duty = 9'd0;
    check("sig_step_c00", 32'(c00), 32'd1);
    check("sig_step_c02", 32'(c02), 32'd1);
    check("sig_step_c10", 32'(c10), 32'd0);
    tick(1);
    check("sig_k1", signature, 32'h1);
    tick(3);
    check("sig_k4", signature, 32'hF);

    // LFSR mode (binary when the feature is compiled out)
    reset_pulse();
    pulse_start(2);
    tick(33);
    mode = 1'b1;
    duty = 9'd300;
    tick(1);
`ifdef PWR_ACT_BANK_LFSR_EN
    check("lfsr_seed_c00", 32'(c00), 32'd1);
    check("lfsr_seed_c01", 32'(c01), 32'd2);
    check("lfsr_seed_c10", 32'(c10), 32'd4);
    tick(1);
    check("lfsr_step_c01", 32'(c01), 32'd4);
    check("lfsr_step_c10", 32'(c10), 32'd8);
    nz_ok = 1'b1;
    for (int i = 0; i < 255; i++) begin
      tick(1);
      if (c00 == '0) nz_ok = 1'b0;
    end
    check("lfsr_nonzero", 32'(nz_ok), 32'd1);
`else
    check("bin_mode1_c01", 32'(c01), 32'd1);
    check("bin_mode1_c10", 32'(c10), 32'd1);
    tick(1);
    check("bin_mode1_c01_2", 32'(c01), 32'd2);
    nz_ok = 1'b0;
    tick(255);
    check("bin_mode1_wrap", 32'(c00), 32'd1);
`endif
    mode = 1'b0;
    duty = 9'd0;

    // asynchronous reset in the middle of a ramp
    reset_pulse();
    duty = 9'd300;
    pulse_start(4);
    tick(32);
    check("mid_pre", 32'(active_ch), 32'd2);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_active", 32'(active_ch), 32'd0);
    check("mid_rst_busy",   32'(busy),      32'd0);
    check("mid_rst_at",     32'(at_target), 32'd0);
    check("mid_rst_sig",    signature,      32'd0);
    check("mid_rst_ctr",    32'(c00),       32'd0);
    @(posedge clk);
    #1;
    rst  = 1'b0;
    duty = 9'd0;
    tick(3);
    check("mid_idle_busy", 32'(busy), 32'd0);
    pulse_start(2);
    tick(15);
    check("mid_re_c15", 32'(active_ch), 32'd0);
    tick(1);
    check("mid_re_c16", 32'(active_ch), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
